core_data_obi_router: RTL
=========================

Name: core_data_obi_router

Overview:
Routes the core's single OBI data manager port to two subordinates by address: L1 (HCI, index 0) and L2 (AXI crossbar, index 1). It tracks outstanding transactions so that responses return in order. It stalls a request whose target differs from the target of in-flight transactions. Unmapped addresses are answered by an internal error responder. It sits between the CV32E40X data port and the HCI / OBI-to-AXI bridges inside the tile.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RID_W, 1, response ID width
N_MAX_TRAN, 1, max outstanding transactions (>=1)
L1_START, 32'h1000_0000, L1 region base (inclusive)
L1_END, 32'h2000_0000, L1 region end (exclusive)
L2_START, 32'h2000_0000, L2 region base (inclusive)
L2_END, 32'h3000_0000, L2 region end (exclusive)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
mgr_req_i  in  1  manager request
mgr_gnt_o  out  1  manager grant
mgr_addr_i  in  ADDR_W  address
mgr_we_i  in  1  write enable
mgr_be_i  in  DATA_W/8  byte enables
mgr_wdata_i  in  DATA_W  write data
mgr_rvalid_o  out  1  response valid
mgr_rdata_o  out  DATA_W  read data
mgr_err_o  out  1  response error
mgr_rid_o  out  RID_W  response ID
sbr_req_o  out  2  per-subordinate request (one-hot or zero)
sbr_addr_o / sbr_we_o / sbr_be_o / sbr_wdata_o  out  ADDR_W/1/DATA_W/8/DATA_W  broadcast from manager
sbr_gnt_i  in  2  per-subordinate grant
sbr_rvalid_i  in  2  per-subordinate response valid
sbr_rdata_i  in  2*DATA_W  packed response data, index 0 in LSBs
sbr_err_i  in  2  per-subordinate error
sbr_rid_i  in  2*RID_W  packed response IDs
stall_o  out  1  request held back by ordering rule (perf counter hook)

Behaviour:
- Decode (combinational):
  - addr in [L1_START, L1_END) gives tgt=0.
  - addr in [L2_START, L2_END) gives tgt=1.
  - Any other address gives tgt=2 (error).
  - Regions are checked in order L1, then L2.
- State:
  - cnt, width $clog2(N_MAX_TRAN+1), number of outstanding transactions.
  - sel_q, 2 bits, target of the outstanding transactions.
  - err_pend_q, 1 bit.
  - Reset values: cnt=0, sel_q=0, err_pend_q=0.
- allow = (cnt==0) OR (cnt<N_MAX_TRAN AND tgt==sel_q).
- Request path:
  - sbr_req_o[tgt] = mgr_req_i & allow, for tgt<2 only. The other bit is 0.
  - mgr_gnt_o = allow & (tgt<2 ? sbr_gnt_i[tgt] : mgr_req_i).
  - The error target grants immediately.
  - This path is combinational with zero added latency. There are no req-to-gnt loops.
- stall_o = mgr_req_i & ~allow.
- Accept = mgr_req_i & mgr_gnt_o. On accept, sel_q <= tgt.
- Error responder:
  - On accept with tgt==2, err_pend_q <= 1 for exactly one cycle.
  - Next cycle it drives mgr_rvalid_o=1, mgr_err_o=1, rdata=0, rid=0.
  - Back-to-back error accepts produce back-to-back responses.
- Response mux, selected by sel_q:
  - 0/1: mgr_rvalid_o = sbr_rvalid_i[sel_q]; rdata, err and rid come from the same index.
  - 2: from the error responder.
  - rvalid from the non-selected subordinate is ignored; an assertion flags it as a protocol violation.
  - With no response, mgr_rdata_o=0, mgr_err_o=0, mgr_rid_o=0.
- Counter:
  - +1 on accept, -1 on mgr_rvalid_o.
  - Both in the same cycle leaves cnt unchanged.
  - cnt==0 allows a new target on the very cycle its last response returns only if that response has already decremented cnt (registered). So a target switch costs at least one cycle after the final rvalid.
- Boundaries:
  - cnt==N_MAX_TRAN blocks even a same-target request until a response frees a slot. The freed slot takes effect the next cycle.
  - rvalid with cnt==0 is an assertion failure; cnt is not decremented below 0.
- Stability: outputs follow the manager inputs, so the OBI stable-until-gnt rule is inherited.
- Reset mid-operation: all state is cleared and in-flight responses are dropped. The subordinates must be reset in the same domain.
- All outputs are 0 while rst_i is high.

Decomposition:
- Shared package (redmule_tile_pkg): ADDR_W, DATA_W, RID_WIDTH, N_MAX_TRAN, the L1/L2 address constants, and an enum for the target (TGT_L1, TGT_L2, TGT_ERR).
- One sub-module, obi_err_sbr: the error responder (err_pend_q register, response generation).

Test Plan:
- Read at 0x1000_0040; L1 grants and returns rdata=0xDEADBEEF one cycle later -> sbr_req_o=2'b01, mgr_rdata_o=0xDEADBEEF, err=0, cnt returns to 0.
- Write to 0x2000_0000 with sbr_gnt_i[1] delayed 3 cycles -> mgr_gnt_o low for 3 cycles, stall_o=0, req and addr stable, single accept.
- N_MAX_TRAN=2: L1 accept, then L2 request before the L1 rvalid -> stall_o=1, sbr_req_o=0 until the cycle after the L1 rvalid, then sbr_req_o=2'b10.
- N_MAX_TRAN=2: three back-to-back L1 requests with slow responses -> third stalls at cnt=2; it is granted the cycle after the first rvalid.
- Access to 0x0000_1000 -> mgr_gnt_o=1 same cycle, next cycle mgr_rvalid_o=1, mgr_err_o=1, rdata=0, no sbr_req_o.
- Assert rst_i with cnt=1 -> all outputs 0 immediately; after release, cnt=0 and an L2 request is forwarded at once.

Source files
------------

// File: rtl/redmule_tile_pkg.sv
// redmule_tile_pkg: shared tile constants and the data-router target encoding
package redmule_tile_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RID_WIDTH = 1;
  localparam int N_MAX_TRAN = 1;
  localparam logic [31:0] L1_START = 32'h1000_0000;
  localparam logic [31:0] L1_END = 32'h2000_0000;
  localparam logic [31:0] L2_START = 32'h2000_0000;
  localparam logic [31:0] L2_END = 32'h3000_0000;
  typedef enum logic [1:0] {TGT_L1 = 2'd0, TGT_L2 = 2'd1, TGT_ERR = 2'd2} tgt_e;
endpackage

// File: rtl/obi_err_sbr.sv
// obi_err_sbr: answers every accepted unmapped access with an error response one cycle later
// ports: clk/rst clock and async reset; hit pulses on an accepted unmapped request;
//        rvalid/rdata/err/rid form the error response (data and id always zero)
module obi_err_sbr #(
  parameter int DATA_W = 32,
  parameter int RID_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [RID_W-1:0]  rid
);
  logic err_pend_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_pend_q <= 1'b0;
    else err_pend_q <= hit;
  end
  assign rvalid = err_pend_q;
  assign err = err_pend_q;
  assign rdata = '0;
  assign rid = '0;
endmodule

// File: rtl/core_data_obi_router.sv
// core_data_obi_router: routes the core OBI data port to L1 (0), L2 (1) or an internal error responder
// ports: clk_i/rst_i clock and async reset; mgr_* core-side OBI manager port;
//        sbr_* two subordinate ports (req/gnt/rvalid/err one bit each, rdata/rid packed, index 0 in LSBs,
//        addr/we/be/wdata broadcast); stall_o flags a request held back by the ordering rule
module core_data_obi_router
  import redmule_tile_pkg::*;
#(
  parameter int ADDR_W = redmule_tile_pkg::ADDR_W,
  parameter int DATA_W = redmule_tile_pkg::DATA_W,
  parameter int RID_W = redmule_tile_pkg::RID_WIDTH,
  parameter int N_MAX_TRAN = redmule_tile_pkg::N_MAX_TRAN,
  parameter logic [ADDR_W-1:0] L1_START = redmule_tile_pkg::L1_START,
  parameter logic [ADDR_W-1:0] L1_END = redmule_tile_pkg::L1_END,
  parameter logic [ADDR_W-1:0] L2_START = redmule_tile_pkg::L2_START,
  parameter logic [ADDR_W-1:0] L2_END = redmule_tile_pkg::L2_END
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mgr_req_i,
  output logic                  mgr_gnt_o,
  input  logic [ADDR_W-1:0]     mgr_addr_i,
  input  logic                  mgr_we_i,
  input  logic [DATA_W/8-1:0]   mgr_be_i,
  input  logic [DATA_W-1:0]     mgr_wdata_i,
  output logic                  mgr_rvalid_o,
  output logic [DATA_W-1:0]     mgr_rdata_o,
  output logic                  mgr_err_o,
  output logic [RID_W-1:0]      mgr_rid_o,
  output logic [1:0]            sbr_req_o,
  output logic [ADDR_W-1:0]     sbr_addr_o,
  output logic                  sbr_we_o,
  output logic [DATA_W/8-1:0]   sbr_be_o,
  output logic [DATA_W-1:0]     sbr_wdata_o,
  input  logic [1:0]            sbr_gnt_i,
  input  logic [1:0]            sbr_rvalid_i,
  input  logic [2*DATA_W-1:0]   sbr_rdata_i,
  input  logic [1:0]            sbr_err_i,
  input  logic [2*RID_W-1:0]    sbr_rid_i,
  output logic                  stall_o
);
  localparam int CW = $clog2(N_MAX_TRAN + 1);
  localparam logic [CW-1:0] MAX = CW'(N_MAX_TRAN);
  logic [CW-1:0] cnt;
  tgt_e tgt, sel_q;
  logic allow, accept, sel_err;
  logic [1:0] sel_mask;
  logic err_rvalid, err_err;
  logic [DATA_W-1:0] err_rdata;
  logic [RID_W-1:0] err_rid;
  always_comb begin
    tgt = (mgr_addr_i >= L1_START && mgr_addr_i < L1_END) ? TGT_L1 :
          (mgr_addr_i >= L2_START && mgr_addr_i < L2_END) ? TGT_L2 : TGT_ERR;
    allow = cnt == '0 || (cnt < MAX && tgt == sel_q);
    sbr_req_o = {2{~rst_i & mgr_req_i & allow}} & {tgt == TGT_L2, tgt == TGT_L1};
    mgr_gnt_o = ~rst_i & allow & (tgt == TGT_ERR ? mgr_req_i : sbr_gnt_i[tgt[0]]);
    stall_o = ~rst_i & mgr_req_i & ~allow;
    accept = mgr_req_i & mgr_gnt_o;
    sbr_addr_o = rst_i ? '0 : mgr_addr_i;
    sbr_we_o = ~rst_i & mgr_we_i;
    sbr_be_o = rst_i ? '0 : mgr_be_i;
    sbr_wdata_o = rst_i ? '0 : mgr_wdata_i;
    sel_err = sel_q == TGT_ERR;
    sel_mask = sel_err ? 2'b00 : sel_q[0] ? 2'b10 : 2'b01;
    mgr_rvalid_o = ~rst_i & (sel_err ? err_rvalid : sbr_rvalid_i[sel_q[0]]);
    mgr_rdata_o = ~mgr_rvalid_o ? '0 : sel_err ? err_rdata :
                  sel_q[0] ? sbr_rdata_i[2*DATA_W-1:DATA_W] : sbr_rdata_i[DATA_W-1:0];
    mgr_err_o = mgr_rvalid_o & (sel_err ? err_err : sbr_err_i[sel_q[0]]);
    mgr_rid_o = ~mgr_rvalid_o ? '0 : sel_err ? err_rid :
                sel_q[0] ? sbr_rid_i[2*RID_W-1:RID_W] : sbr_rid_i[RID_W-1:0];
  end
  // cnt never underflows: a stray response with nothing outstanding is only flagged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      sel_q <= TGT_L1;
    end else begin
      cnt <= cnt + CW'(accept) - CW'(mgr_rvalid_o && cnt != '0);
      if (accept) sel_q <= tgt;
    end
  end
  obi_err_sbr #(.DATA_W(DATA_W), .RID_W(RID_W)) u_err (
    .clk(clk_i),
    .rst(rst_i),
    .hit(accept && tgt == TGT_ERR),
    .rvalid(err_rvalid),
    .rdata(err_rdata),
    .err(err_err),
    .rid(err_rid)
  );
  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i) mgr_rvalid_o |-> cnt != '0);
  a_no_foreign_rvalid: assert property (@(posedge clk_i) disable iff (rst_i) (sbr_rvalid_i & ~sel_mask) == 2'b00);
endmodule
